mdu_ctrl: RTL

- E-stage multiply/divide unit controller for the five-stage MIPS pipeline.
- Owns the HI/LO registers and sequences multi-cycle mult/multu/div/divu operations.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Raises a stall request toward D while an operation is pending and the D-stage instruction touches HI/LO.

---
 rtl/mdu_ctrl_if.sv | 21 ++
 rtl/mdu_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage pipeline <-> multiply/divide unit signal bundle.
// The pipeline drives through master; mdu_ctrl connects through slave.
interface mdu_ctrl_if;
   logic [2:0]  E_MDUOp;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        D_HILO_operation;
   logic [31:0] E_HI;
   logic [31:0] E_LO;
   logic        start;
   logic        busy;
   logic        MDU_stall;
   modport master (
      output E_MDUOp, E_A, E_B, D_HILO_operation,
      input  E_HI, E_LO, start, busy, MDU_stall
   );
   modport slave (
      input  E_MDUOp, E_A, E_B, D_HILO_operation,
      output E_HI, E_LO, start, busy, MDU_stall
   );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage mult/div controller owning HI/LO; the result is computed at start and committed after the busy window.
// Optional macro MDU_MADD_EN adds op 7 (madd: {HI,LO} += signed E_A*E_B).
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_ctrl_if.slave  bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
   logic [63:0] cur, sprod, uprod, acc, res;
   logic [31:0] sq, sr, uq, ur;
   logic        b_zero, is_div, start_op;
   assign cur    = {hi_q, lo_q};
   assign b_zero = bus.E_B == 32'd0;
   assign is_div = bus.E_MDUOp == 3'd3 || bus.E_MDUOp == 3'd4;
   assign sprod  = $signed({{32{bus.E_A[31]}}, bus.E_A}) * $signed({{32{bus.E_B[31]}}, bus.E_B});
   assign uprod  = {32'd0, bus.E_A} * {32'd0, bus.E_B};
   assign sq     = $signed(bus.E_A) / $signed(bus.E_B);
   assign sr     = $signed(bus.E_A) % $signed(bus.E_B);
   assign uq     = bus.E_A / bus.E_B;
   assign ur     = bus.E_A % bus.E_B;
`ifdef MDU_MADD_EN
   assign acc      = cur + sprod;
   assign start_op = (bus.E_MDUOp >= 3'd1 && bus.E_MDUOp <= 3'd4) || bus.E_MDUOp == 3'd7;
`else
   assign acc      = cur;
   assign start_op = bus.E_MDUOp >= 3'd1 && bus.E_MDUOp <= 3'd4;
`endif
   // Divide by zero reloads the current HI/LO, so completion leaves them unchanged.
   assign res = bus.E_MDUOp == 3'd1 ? sprod :
                bus.E_MDUOp == 3'd2 ? uprod :
                bus.E_MDUOp == 3'd3 ? (b_zero ? cur : {sr, sq}) :
                bus.E_MDUOp == 3'd4 ? (b_zero ? cur : {ur, uq}) : acc;
   assign bus.start     = state_q == IDLE && start_op;
   assign bus.busy      = state_q == BUSY;
   assign bus.MDU_stall = bus.D_HILO_operation && (bus.start || bus.busy);
   assign bus.E_HI      = hi_q;
   assign bus.E_LO      = lo_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      thi_d   = thi_q;
      tlo_d   = tlo_q;
      if (state_q == IDLE) begin
         if (bus.start) begin
            state_d        = BUSY;
            cnt_d          = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            {thi_d, tlo_d} = res;
         end else if (bus.E_MDUOp == 3'd5) hi_d = bus.E_A;
         else if (bus.E_MDUOp == 3'd6) lo_d = bus.E_A;
      end else begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = IDLE;
            hi_d    = thi_q;
            lo_d    = tlo_q;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         thi_q   <= '0;
         tlo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         thi_q   <= thi_d;
         tlo_q   <= tlo_d;
      end
   end
endmodule
